// File: rtl/barrel_shift_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_shift_arbiter_if
//  Purpose  : Bundle of every requester-facing and shifter-facing signal of
//             barrel_shift_arbiter. Two requesters (A, B) send shift commands
//             over valid/ready and receive results over rvalid/rready. The
//             shared combinational shifter is driven through the sh_* group.
//  Ports    : (interface signals)
//             a_/b_valid, a_/b_ready     command handshake
//             a_/b_data, a_/b_shamt      operand, shift amount
//             a_/b_lr, a_/b_al           1=left/0=right, 1=arithmetic/0=logical
//             a_/b_rvalid, a_/b_rready   response handshake
//             r_data                     result shared by both responses
//             sh_din, sh_shamt, sh_lr,   shifter control (arbiter -> shifter)
//             sh_al
//             sh_dout                    shifter result (shifter -> arbiter)
//             busy                       arbiter is not idle
//  Modports : slave  - the arbiter side
//             master - the requester / shifter environment side
//  Revision : 1.0  initial release
// ============================================================================
interface barrel_shift_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) ();

   // Requester A command channel
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic [SHW-1:0]   a_shamt;
   logic             a_lr;
   logic             a_al;

   // Requester B command channel
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;
   logic [SHW-1:0]   b_shamt;
   logic             b_lr;
   logic             b_al;

   // Response channels
   logic             a_rvalid;
   logic             a_rready;
   logic             b_rvalid;
   logic             b_rready;
   logic [WIDTH-1:0] r_data;

   // Shared shifter connection
   logic [WIDTH-1:0] sh_din;
   logic [SHW-1:0]   sh_shamt;
   logic             sh_lr;
   logic             sh_al;
   logic [WIDTH-1:0] sh_dout;

   // Status
   logic             busy;

   modport slave (
      input  a_valid, a_data, a_shamt, a_lr, a_al,
      input  b_valid, b_data, b_shamt, b_lr, b_al,
      input  a_rready, b_rready,
      input  sh_dout,
      output a_ready, b_ready,
      output a_rvalid, b_rvalid, r_data,
      output sh_din, sh_shamt, sh_lr, sh_al,
      output busy
   );

   modport master (
      output a_valid, a_data, a_shamt, a_lr, a_al,
      output b_valid, b_data, b_shamt, b_lr, b_al,
      output a_rready, b_rready,
      output sh_dout,
      input  a_ready, b_ready,
      input  a_rvalid, b_rvalid, r_data,
      input  sh_din, sh_shamt, sh_lr, sh_al,
      input  busy
   );

endinterface
`default_nettype wire

// File: rtl/barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_shift_arbiter
//  Purpose  : Shares one combinational barrel shifter between two requesters.
//             A command is accepted from one requester while idle (round-robin
//             on contention), held in a command register that drives the
//             shifter, the shifter result is registered one cycle later, and
//             the result is held on the granted requester's response channel
//             until that requester consumes it.
//  Params   : WIDTH - data width (default 8)
//             SHW   - shift-amount width, equal to log2(WIDTH) (default 3)
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - barrel_shift_arbiter_if.slave, carries all command,
//                     response, shifter and status signals
//  Timing   : grant edge T -> ISSUE during T..T+1 -> r_data captured at T+1,
//             *_rvalid high from T+1 until the matching *_rready is sampled.
//             Minimum command period is 3 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module barrel_shift_arbiter #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   barrel_shift_arbiter_if.slave bus
);

   // ------------------------------------------------------------------------
   // State and constants
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

   state_t           state_q,    state_d;
   logic             rr_q,       rr_d;        // preferred requester on contention
   logic             gnt_q,      gnt_d;       // owner of the in-flight command
   logic [WIDTH-1:0] din_q,      din_d;
   logic [SHW-1:0]   shamt_q,    shamt_d;
   logic             lr_q,       lr_d;
   logic             al_q,       al_d;
   logic [WIDTH-1:0] rdata_q,    rdata_d;
   logic             a_rvalid_q, a_rvalid_d;
   logic             b_rvalid_q, b_rvalid_d;
   logic             busy_q,     busy_d;

   logic             w_idle;
   logic             w_both;
   logic             w_pick_b;
   logic             w_accept;
   logic             w_resp_done;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   assign w_idle      = (state_q == ST_IDLE);
   assign w_both      = bus.a_valid & bus.b_valid;
   // A lone requester always wins; rr only breaks ties.
   assign w_pick_b    = w_both ? rr_q : bus.b_valid;
   assign w_accept    = w_idle & (bus.a_valid | bus.b_valid);
   // Only the owner's rready can retire the response.
   assign w_resp_done = (gnt_q == GNT_B) ? bus.b_rready : bus.a_rready;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      din_d      = din_q;
      shamt_d    = shamt_q;
      lr_d       = lr_q;
      al_d       = al_q;
      rdata_d    = rdata_q;
      a_rvalid_d = a_rvalid_q;
      b_rvalid_d = b_rvalid_q;
      busy_d     = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               gnt_d   = w_pick_b;
               din_d   = w_pick_b ? bus.b_data  : bus.a_data;
               shamt_d = w_pick_b ? bus.b_shamt : bus.a_shamt;
               lr_d    = w_pick_b ? bus.b_lr    : bus.a_lr;
               al_d    = w_pick_b ? bus.b_al    : bus.a_al;
               busy_d  = 1'b1;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // The shifter has had a full cycle on the command register.
            rdata_d    = bus.sh_dout;
            a_rvalid_d = (gnt_q == GNT_A);
            b_rvalid_d = (gnt_q == GNT_B);
            state_d    = ST_RESP;
         end

         ST_RESP: begin
            if (w_resp_done) begin
               a_rvalid_d = 1'b0;
               b_rvalid_d = 1'b0;
               busy_d     = 1'b0;
               // Fairness pointer moves only when a transaction retires.
               rr_d       = ~gnt_q;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            a_rvalid_d = 1'b0;
            b_rvalid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_q       <= GNT_A;
         gnt_q      <= GNT_A;
         din_q      <= '0;
         shamt_q    <= '0;
         lr_q       <= 1'b0;
         al_q       <= 1'b0;
         rdata_q    <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         din_q      <= din_d;
         shamt_q    <= shamt_d;
         lr_q       <= lr_d;
         al_q       <= al_d;
         rdata_q    <= rdata_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         busy_q     <= busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // ready must be a same-cycle acknowledge, so it is the only combinational
   // output; rst_n gates it so it drops the moment reset is asserted even
   // when a requester keeps valid high.
   assign bus.a_ready  = rst_n & w_accept & ~w_pick_b;
   assign bus.b_ready  = rst_n & w_accept &  w_pick_b;

   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.r_data   = rdata_q;

   assign bus.sh_din   = din_q;
   assign bus.sh_shamt = shamt_q;
   assign bus.sh_lr    = lr_q;
   assign bus.sh_al    = al_q;

   assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barrel_shift_arbiter
//  Purpose  : Self-checking bench for barrel_shift_arbiter. Plays the role of
//             both requesters and of the shared barrel shifter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_barrel_shift_arbiter;

   localparam int WIDTH = 8;
   localparam int SHW   = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   barrel_shift_arbiter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

   barrel_shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural barrel shifter
   function automatic logic [WIDTH-1:0] shift_ref(input logic [WIDTH-1:0] d,
                                                  input logic [SHW-1:0]   s,
                                                  input logic             lr,
                                                  input logic             al);
      logic signed [WIDTH-1:0] sd;
      sd = d;
      if (lr)      return d << s;
      else if (al) return sd >>> s;
      else         return d >> s;
   endfunction

   assign bus.sh_dout = shift_ref(bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al);

   task automatic idle_inputs();
      bus.a_valid = 0; bus.a_data = '0; bus.a_shamt = '0; bus.a_lr = 0; bus.a_al = 0;
      bus.b_valid = 0; bus.b_data = '0; bus.b_shamt = '0; bus.b_lr = 0; bus.b_al = 0;
      bus.a_rready = 0; bus.b_rready = 0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [4:0]  ctl;
      logic [20:0] dat;
      idle_inputs();
      rst_n = 0;
      #1;
      ctl = {bus.a_ready, bus.b_ready, bus.a_rvalid, bus.b_rvalid, bus.busy};
      checks++;
      if (ctl !== 5'b0) begin failures++; $display("FAIL rst_initial_ctl: got %b expected 00000", ctl); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      // Bring an A command into RESP, then reset it away.
      bus.a_valid = 1; bus.a_data = 8'h5A; bus.a_shamt = 3'd1; bus.a_lr = 1;
      @(posedge clk); @(negedge clk);
      bus.a_valid = 0;
      @(posedge clk); @(negedge clk);
      #1;
      checks++;
      if (bus.a_rvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_resp: got %b expected 1", bus.a_rvalid); end
      bus.a_valid = 1; bus.b_valid = 1;
      rst_n = 0;
      #1;
      ctl = {bus.a_ready, bus.b_ready, bus.a_rvalid, bus.b_rvalid, bus.busy};
      dat = {bus.r_data, bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al};
      checks++;
      if (ctl !== 5'b0) begin failures++; $display("FAIL rst_async_ctl: got %b expected 00000", ctl); end
      checks++;
      if (dat !== 21'b0) begin failures++; $display("FAIL rst_async_data: got %h expected 0", dat); end
      @(posedge clk); @(negedge clk);
      rst_n = 1;
      #1;
      checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         begin failures++; $display("FAIL rst_first_grant: got %b expected 10", {bus.a_ready, bus.b_ready}); end
      @(posedge clk); @(negedge clk);
      bus.a_valid = 0; bus.b_valid = 0; bus.a_rready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk); bus.a_rready = 0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_single_a();
      @(negedge clk);
      bus.a_valid = 1; bus.a_data = 8'b1001_0110; bus.a_shamt = 3'd2; bus.a_lr = 0; bus.a_al = 1;
      bus.a_rready = 0;
      #1;
      checks++;
      if ({bus.a_ready, bus.b_ready, bus.busy} !== 3'b100)
         begin failures++; $display("FAIL a_accept: got %b expected 100", {bus.a_ready, bus.b_ready, bus.busy}); end
      @(posedge clk); @(negedge clk);
      // The operand changes right after acceptance; it must not leak through.
      bus.a_valid = 0; bus.a_data = 8'hFF;
      #1;
      checks++;
      if ({bus.a_ready, bus.a_rvalid, bus.busy} !== 3'b001)
         begin failures++; $display("FAIL a_issue: got %b expected 001", {bus.a_ready, bus.a_rvalid, bus.busy}); end
      @(posedge clk); @(negedge clk);
      #1;
      checks++;
      if ({bus.a_rvalid, bus.b_rvalid} !== 2'b10)
         begin failures++; $display("FAIL a_rvalid: got %b expected 10", {bus.a_rvalid, bus.b_rvalid}); end
      checks++;
      if (bus.r_data !== 8'b1110_0101)
         begin failures++; $display("FAIL a_sra_result: got %h expected e5", bus.r_data); end
      bus.a_rready = 1;
      @(posedge clk); @(negedge clk);
      bus.a_rready = 0;
      #1;
      checks++;
      if ({bus.a_rvalid, bus.busy} !== 2'b00)
         begin failures++; $display("FAIL a_retire: got %b expected 00", {bus.a_rvalid, bus.busy}); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_single_b();
      @(negedge clk);
      bus.b_valid = 1; bus.b_data = 8'h07; bus.b_shamt = 3'd3; bus.b_lr = 1; bus.b_al = 0;
      bus.b_rready = 0;
      #1;
      checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b01)
         begin failures++; $display("FAIL b_accept: got %b expected 01", {bus.a_ready, bus.b_ready}); end
      @(posedge clk); @(negedge clk);
      bus.b_valid = 0; bus.b_data = 8'h00;
      #1;
      checks++;
      if ({bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al} !== {8'h07, 3'd3, 1'b1, 1'b0})
         begin failures++; $display("FAIL b_sh_ctrl: got %h %h %b %b expected 07 3 1 0",
                                    bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al); end
      @(posedge clk); @(negedge clk);
      #1;
      checks++;
      if ({bus.a_rvalid, bus.b_rvalid} !== 2'b01)
         begin failures++; $display("FAIL b_rvalid: got %b expected 01", {bus.a_rvalid, bus.b_rvalid}); end
      checks++;
      if (bus.r_data !== 8'h38)
         begin failures++; $display("FAIL b_sll_result: got %h expected 38", bus.r_data); end
      bus.b_rready = 1;
      @(posedge clk); @(negedge clk);
      bus.b_rready = 0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_contention();
      logic [WIDTH-1:0] res_a, res_b, exp_d;
      int   ngr      = 0;
      int   last_cyc = 0;
      logic exp_b    = 1'b0;
      @(negedge clk);
      bus.a_data = WIDTH'($urandom); bus.a_shamt = SHW'($urandom); bus.a_lr = 1'($urandom); bus.a_al = 1'($urandom);
      bus.b_data = WIDTH'($urandom); bus.b_shamt = SHW'($urandom); bus.b_lr = 1'($urandom); bus.b_al = 1'($urandom);
      res_a = shift_ref(bus.a_data, bus.a_shamt, bus.a_lr, bus.a_al);
      res_b = shift_ref(bus.b_data, bus.b_shamt, bus.b_lr, bus.b_al);
      bus.a_valid = 1; bus.b_valid = 1; bus.a_rready = 1; bus.b_rready = 1;
      for (int cyc = 0; cyc < 24 && ngr < 6; cyc++) begin
         #1;
         if (bus.a_ready || bus.b_ready) begin
            checks++;
            if ({bus.a_ready, bus.b_ready} !== {~exp_b, exp_b})
               begin failures++; $display("FAIL cont_order: grant %0d got %b expected %b",
                                          ngr, {bus.a_ready, bus.b_ready}, {~exp_b, exp_b}); end
            if (ngr > 0) begin
               checks++;
               if (cyc - last_cyc != 3)
                  begin failures++; $display("FAIL cont_period: got %0d expected 3", cyc - last_cyc); end
            end
            last_cyc = cyc;
            ngr++;
            exp_b = ~exp_b;
         end
         if (bus.a_rvalid || bus.b_rvalid) begin
            exp_d = bus.b_rvalid ? res_b : res_a;
            checks++;
            if ((bus.a_rvalid && bus.b_rvalid) || bus.r_data !== exp_d)
               begin failures++; $display("FAIL cont_result: got %h rv=%b expected %h",
                                          bus.r_data, {bus.a_rvalid, bus.b_rvalid}, exp_d); end
         end
         @(negedge clk);
      end
      checks++;
      if (ngr != 6) begin failures++; $display("FAIL cont_count: got %0d expected 6", ngr); end
      bus.a_valid = 0; bus.b_valid = 0;
      repeat (4) @(negedge clk);
      bus.a_rready = 0; bus.b_rready = 0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_backpressure();
      logic [WIDTH-1:0] exp_d;
      @(negedge clk);
      bus.a_data = WIDTH'($urandom); bus.a_shamt = SHW'($urandom); bus.a_lr = 1'($urandom); bus.a_al = 1'($urandom);
      exp_d = shift_ref(bus.a_data, bus.a_shamt, bus.a_lr, bus.a_al);
      bus.b_data = 8'hC3; bus.b_shamt = 3'd1; bus.b_lr = 0; bus.b_al = 1;
      bus.a_valid = 1; bus.b_valid = 1; bus.a_rready = 0; bus.b_rready = 1;
      #1;
      checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         begin failures++; $display("FAIL bp_grant_a: got %b expected 10", {bus.a_ready, bus.b_ready}); end
      @(posedge clk); @(negedge clk);
      bus.a_valid = 0; bus.a_data = ~bus.a_data;
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({bus.a_rvalid, bus.b_rvalid, bus.b_ready} !== 3'b100 || bus.r_data !== exp_d)
            begin failures++; $display("FAIL bp_hold: cycle %0d got rv/brdy=%b data=%h expected 100 data=%h",
                                       i, {bus.a_rvalid, bus.b_rvalid, bus.b_ready}, bus.r_data, exp_d); end
         @(negedge clk);
      end
      bus.a_rready = 1;
      #1;
      checks++;
      if (bus.b_ready !== 1'b0) begin failures++; $display("FAIL bp_no_early_b: got %b expected 0", bus.b_ready); end
      @(negedge clk);
      bus.a_rready = 0;
      #1;
      checks++;
      if ({bus.b_ready, bus.a_rvalid} !== 2'b10)
         begin failures++; $display("FAIL bp_b_grant: got %b expected 10", {bus.b_ready, bus.a_rvalid}); end
      @(posedge clk); @(negedge clk);
      bus.b_valid = 0;
      @(posedge clk); @(negedge clk);
      #1;
      checks++;
      if ({bus.b_rvalid, bus.r_data} !== {1'b1, 8'hE1})
         begin failures++; $display("FAIL bp_b_result: got %b %h expected 1 e1", bus.b_rvalid, bus.r_data); end
      repeat (2) @(negedge clk);
      bus.b_rready = 0;
   endtask

   // ------------------------------------------------------------------------
   // Random traffic against a transaction-level model: at most one command
   // is outstanding; its result is owed from the edge after acceptance until
   // the owner's rready is seen, after which the other requester is preferred.
   task automatic test_random();
      logic             m_pend = 1'b0;
      logic             m_who  = 1'b0;
      logic             m_rr   = 1'b0;
      int               m_age  = 0;
      logic [WIDTH-1:0] m_res  = '0;
      logic             exp_ar, exp_br, exp_rva, exp_rvb;
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         bus.a_valid  = ($urandom_range(0, 2) != 0);
         bus.b_valid  = ($urandom_range(0, 2) != 0);
         bus.a_data   = WIDTH'($urandom); bus.a_shamt = SHW'($urandom);
         bus.a_lr     = 1'($urandom);     bus.a_al    = 1'($urandom);
         bus.b_data   = WIDTH'($urandom); bus.b_shamt = SHW'($urandom);
         bus.b_lr     = 1'($urandom);     bus.b_al    = 1'($urandom);
         bus.a_rready = 1'($urandom);
         bus.b_rready = 1'($urandom);
         #1;
         exp_ar  = !m_pend && bus.a_valid && (!bus.b_valid || !m_rr);
         exp_br  = !m_pend && bus.b_valid && (!bus.a_valid ||  m_rr);
         exp_rva = m_pend && m_age >= 1 && !m_who;
         exp_rvb = m_pend && m_age >= 1 &&  m_who;
         checks++;
         if ({bus.a_ready, bus.b_ready} !== {exp_ar, exp_br})
            begin failures++; $display("FAIL rnd_ready: cyc %0d got %b expected %b",
                                       cyc, {bus.a_ready, bus.b_ready}, {exp_ar, exp_br}); end
         checks++;
         if ({bus.a_rvalid, bus.b_rvalid, bus.busy} !== {exp_rva, exp_rvb, m_pend})
            begin failures++; $display("FAIL rnd_rvalid_busy: cyc %0d got %b expected %b",
                                       cyc, {bus.a_rvalid, bus.b_rvalid, bus.busy}, {exp_rva, exp_rvb, m_pend}); end
         if (exp_rva || exp_rvb) begin
            checks++;
            if (bus.r_data !== m_res)
               begin failures++; $display("FAIL rnd_data: cyc %0d got %h expected %h", cyc, bus.r_data, m_res); end
         end
         // Advance the model across the coming clock edge.
         if (!m_pend) begin
            if (exp_ar || exp_br) begin
               m_pend = 1'b1;
               m_who  = exp_br;
               m_age  = 0;
               m_res  = exp_br ? shift_ref(bus.b_data, bus.b_shamt, bus.b_lr, bus.b_al)
                               : shift_ref(bus.a_data, bus.a_shamt, bus.a_lr, bus.a_al);
            end
         end else if (m_age >= 1 && (m_who ? bus.b_rready : bus.a_rready)) begin
            m_pend = 1'b0;
            m_rr   = ~m_who;
         end else begin
            m_age++;
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single_a();
      test_single_b();
      test_contention();
      test_backpressure();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Controller that shares one 8-bit combinational barrel shifter between two requesters (A, B). It accepts shift commands over valid/ready, grants the shifter round-robin, and drives the shifter's data and control inputs. It registers the shifter output and returns the result to the granted requester over a valid/ready response channel. It sits between the requesting datapath blocks and the shared barrel shifter instance.

## Interface

- `WIDTH`, default 8: data width of the shifter.
- `SHW`, default 3: shift-amount width; must equal log2(`WIDTH`).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `a_valid`, `b_valid` input, 1 bit each: command present.
- `a_ready`, `b_ready` output, 1 bit each: command accepted this cycle; a one-cycle pulse.
- `a_data`, `b_data` input, `WIDTH` bits each: operand.
- `a_shamt`, `b_shamt` input, `SHW` bits each: shift amount.
- `a_lr`, `b_lr` input, 1 bit each: 1 = shift left, 0 = shift right.
- `a_al`, `b_al` input, 1 bit each: 1 = arithmetic (sign-fill on right shift), 0 = logical.
- `a_rvalid`, `b_rvalid` output, 1 bit each: result valid.
- `a_rready`, `b_rready` input, 1 bit each: result consumed.
- `r_data` output, `WIDTH` bits: result, shared by both response channels.
- `sh_din` output, `WIDTH` bits: shifter operand.
- `sh_shamt` output, `SHW` bits: shifter amount.
- `sh_lr`, `sh_al` output, 1 bit each: shifter direction and mode.
- `sh_dout` input, `WIDTH` bits: combinational shifter result.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation

- FSM states are IDLE, ISSUE and RESP. The encoding is free.
- IDLE:
  - If exactly one of `a_valid`/`b_valid` is high, grant that requester.
  - If both are high, grant the requester selected by the round-robin pointer `rr`, where 0 = A and 1 = B.
  - On a grant, pulse the granted `*_ready` for this cycle, latch data/shamt/lr/al into the command register, record the grant, and go to ISSUE.
  - If neither is valid, stay in IDLE.
- ISSUE: `sh_*` carry the latched command. At the clock edge, capture `sh_dout` into the `r_data` register and go to RESP.
- RESP:
  - Hold the granted requester's `*_rvalid` high and `r_data` stable.
  - When the matching `*_rready` is high, go to IDLE on that edge and set `rr` to the non-granted requester.
  - The other requester's `*_rready` is ignored.
- `sh_din`/`sh_shamt`/`sh_lr`/`sh_al` always reflect the command register. The shifter is only sampled in ISSUE.
- No new command is accepted outside IDLE; `*_ready` is 0 in ISSUE and RESP.
- Requester inputs are sampled only in IDLE on the grant cycle. Later changes do not affect an in-flight command.
- The non-granted `*_rvalid` is always 0. Both `*_rvalid` are never high together.

## Timing

- Reset (asynchronous, `rst_n` = 0):
  - State = IDLE, `rr` = 0 (A preferred first).
  - Command register, `r_data`, all `sh_*` = 0.
  - `a_ready`, `b_ready`, `a_rvalid`, `b_rvalid`, `busy` = 0.
- Reset mid-operation: any in-flight command is discarded and no response is issued. Outputs take reset values immediately, without waiting for a clock edge.
- Accept at edge T (ready high in cycle T-1..T). ISSUE runs in cycle T..T+1 and `r_data` is captured at T+1. `*_rvalid` is high from T+1.
- Minimum command-to-command period is 3 cycles when `*_rready` is tied high. This gives a throughput of one result per 3 cycles.
- Back-to-back fairness: if both requesters hold valid continuously, grants alternate A, B, A, B.
- A requester that drops valid before being granted loses no state; nothing is queued.
- `rr` updates only on RESP exit, never on the grant.
- `busy` is high in the grant cycle's following state through the RESP exit edge. It is low only in IDLE.

## Test plan

- Reset and idle: assert `rst_n` = 0 mid-RESP, then release. Required: every output is 0 and the next grant goes to A if both are valid.
- Single A command, arithmetic right: `a_data` = 8'b1001_0110, `a_shamt` = 2, `a_lr` = 0, `a_al` = 1, with a behavioural shifter model. Required: `a_ready` pulses 1 cycle, and `a_rvalid` rises 2 cycles after acceptance with `r_data` = 8'b1110_0101.
- Single B command, logical left: `b_data` = 8'h07, `b_shamt` = 3, `b_lr` = 1, `b_al` = 0. Required: `b_rvalid` with `r_data` = 8'h38, and `a_rvalid` stays 0.
- Contention: both valid continuously for 6 commands, `*_rready` tied 1. Required: grant order A, B, A, B, A, B, with one result every 3 cycles.
- Response backpressure: hold `a_rready` = 0 for 5 cycles while `b_valid` = 1. Required: `r_data` is stable, `b_ready` stays 0, and B is granted the cycle after `a_rready` is sampled high.
- Input change after accept: change `a_data` to 8'hFF the cycle after `a_ready`. Required: the result reflects the originally latched operand.
